// File: rtl/kv_ttl_store.sv
// Key/value/TTL store: small fully-associative table with parallel key compare,
// one request in flight, and per-entry TTL countdown driven by a prescaled tick.
module kv_ttl_store #(
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32,
  parameter int NUM_ENTRIES = 8,
  parameter int TICK_DIV    = 1000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mem_cmd_valid,
  input  logic                               mem_cmd_write,
  input  logic [KEY_WIDTH-1:0]               mem_cmd_key,
  input  logic [VALUE_WIDTH-1:0]             mem_cmd_value,
  input  logic [TTL_WIDTH-1:0]               mem_cmd_ttl,
  output logic                               mem_cmd_ready,
  output logic                               mem_resp_valid,
  output logic                               mem_resp_hit,
  output logic [VALUE_WIDTH-1:0]             mem_resp_value,
  output logic [TTL_WIDTH-1:0]               mem_resp_ttl,
  input  logic                               mem_resp_ready,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int OCC_W = $clog2(NUM_ENTRIES+1);
  localparam logic [TTL_WIDTH-1:0] TTL_INF = '1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_hit_q, resp_hit_d;
  logic [VALUE_WIDTH-1:0]   resp_value_q, resp_value_d;
  logic [TTL_WIDTH-1:0]     resp_ttl_q, resp_ttl_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [PRE_W-1:0]         presc_q, presc_d;
  logic [NUM_ENTRIES-1:0]   valid_q, valid_d;

  logic                     req_write_q, req_write_d;
  logic [KEY_WIDTH-1:0]     req_key_q, req_key_d;
  logic [VALUE_WIDTH-1:0]   req_value_q, req_value_d;
  logic [TTL_WIDTH-1:0]     req_ttl_q, req_ttl_d;
  logic [KEY_WIDTH-1:0]     key_q [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0]     key_d [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0]   val_q [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0]   val_d [NUM_ENTRIES];
  logic [TTL_WIDTH-1:0]     ttl_q [NUM_ENTRIES];
  logic [TTL_WIDTH-1:0]     ttl_d [NUM_ENTRIES];

  logic                     match_any, free_any, tick, do_store;
  logic [IDX_W-1:0]         match_idx, free_idx, tgt_idx;

  // Descending scan so the lowest index wins for both match and free slot.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == req_key_q)) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_value_d = resp_value_q;
    resp_ttl_d   = resp_ttl_q;
    valid_d      = valid_q;
    req_write_d  = req_write_q;
    req_key_d    = req_key_q;
    req_value_d  = req_value_q;
    req_ttl_d    = req_ttl_q;
    key_d        = key_q;
    val_d        = val_q;
    ttl_d        = ttl_q;
    do_store     = 1'b0;
    tgt_idx      = match_idx;

    tick    = (presc_q == PRE_W'(TICK_DIV-1));
    presc_d = tick ? '0 : presc_q + PRE_W'(1);

    // Tick ageing first; a same-cycle table commit below overrides it.
    if (tick) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i] && (ttl_q[i] != TTL_INF)) begin
          if (ttl_q[i] <= TTL_WIDTH'(1)) begin
            valid_d[i] = 1'b0;
            ttl_d[i]   = '0;
          end else begin
            ttl_d[i] = ttl_q[i] - TTL_WIDTH'(1);
          end
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (mem_cmd_valid && cmd_ready_q) begin
          req_write_d = mem_cmd_write;
          req_key_d   = mem_cmd_key;
          req_value_d = mem_cmd_value;
          req_ttl_d   = mem_cmd_ttl;
          cmd_ready_d = 1'b0;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        if (!req_write_q) begin
          resp_hit_d   = match_any;
          resp_value_d = match_any ? val_q[match_idx] : '0;
          resp_ttl_d   = match_any ? ttl_q[match_idx] : '0;
        end else if (req_ttl_q == '0) begin
          resp_hit_d   = match_any;
          resp_value_d = '0;
          resp_ttl_d   = '0;
          if (match_any) valid_d[match_idx] = 1'b0;
        end else begin
          resp_value_d = req_value_q;
          resp_ttl_d   = req_ttl_q;
          if (match_any) begin
            do_store = 1'b1;
          end else if (free_any) begin
            do_store = 1'b1;
            tgt_idx  = free_idx;
          end
          resp_hit_d = do_store;
          if (do_store) begin
            valid_d[tgt_idx] = 1'b1;
            key_d[tgt_idx]   = req_key_q;
            val_d[tgt_idx]   = req_value_q;
            ttl_d[tgt_idx]   = req_ttl_q;
          end
        end
      end
      RESP: begin
        if (mem_resp_ready) begin
          resp_valid_d = 1'b0;
          cmd_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    occ_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_value_q <= '0;
      resp_ttl_q   <= '0;
      occ_q        <= '0;
      presc_q      <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_value_q <= resp_value_d;
      resp_ttl_q   <= resp_ttl_d;
      occ_q        <= occ_d;
      presc_q      <= presc_d;
      valid_q      <= valid_d;
    end
  end

  // Payload storage is qualified by valid_q / state, so it needs no reset.
  always_ff @(posedge clk) begin
    req_write_q <= req_write_d;
    req_key_q   <= req_key_d;
    req_value_q <= req_value_d;
    req_ttl_q   <= req_ttl_d;
    key_q       <= key_d;
    val_q       <= val_d;
    ttl_q       <= ttl_d;
  end

  assign mem_cmd_ready  = cmd_ready_q;
  assign mem_resp_valid = resp_valid_q;
  assign mem_resp_hit   = resp_hit_q;
  assign mem_resp_value = resp_value_q;
  assign mem_resp_ttl   = resp_ttl_q;
  assign occupancy      = occ_q;

endmodule
